inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32, PC width.
REQ-003 SHALL have parameter INST_W, default 32, instruction width.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports clk, rst.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  branch flush; discards all entries.
- push_valid_i  in  1  fetch side offers an entry.
- push_pc_i  in  ADDR_W  PC of the offered instruction.
- push_inst_i  in  INST_W  offered instruction word.
- push_ready_o  out  1  queue can accept an entry.
- pop_valid_o  out  1  head entry available.
- pop_pc_o  out  ADDR_W  head PC.
- pop_inst_o  out  INST_W  head instruction.
- pop_ready_i  in  1  decode side consumes the head.
- count_o  out  clog2(DEPTH+1)  current occupancy.

Function
REQ-006 SHALL be a circular buffer with read/write pointers of log2(DEPTH) bits plus one wrap bit each.
REQ-007 SHALL accept a push only when push_valid_i and push_ready_o are both high at the clock edge.
REQ-008 SHALL complete a pop only when pop_valid_o and pop_ready_i are both high at the clock edge.
REQ-009 SHALL drive push_ready_o = (count != DEPTH) && !flush_i && !rst.
- There SHALL be no push-while-full pass-through.
REQ-010 SHALL drive pop_valid_o = (count != 0) && !flush_i && !rst, unless REQ-021 applies.
REQ-011 SHALL drive pop_pc_o and pop_inst_o with the head entry when pop_valid_o is high, and with zero otherwise.
REQ-012 SHALL present a pushed entry at the head no earlier than the next cycle, giving a push-to-pop latency of 1 cycle, unless REQ-021 applies.
REQ-013 SHALL leave count unchanged and advance both pointers on a simultaneous push and pop.
REQ-014 SHALL wrap each pointer from DEPTH-1 to 0 and toggle its wrap bit.
- Full is defined as equal indices with differing wrap bits.
- Empty is defined as equal pointers.
REQ-015 SHALL ignore, without any state change, a push when not ready and a pop when not valid.
REQ-016 SHALL, on flush_i, set both pointers and count to 0 at the next edge, discarding any same-cycle push and pop.
REQ-017 SHALL preserve FIFO order; entries leave in the exact order they were accepted.
REQ-018 SHALL drive count_o directly from a registered occupancy counter.

Reset
REQ-019 SHALL, when rst is high at a clock edge, clear both pointers and count to 0.
- rst SHALL take priority over flush_i, push and pop.
- Storage array contents SHALL NOT be reset.
REQ-020 SHALL, while rst is high, drive push_ready_o=0, pop_valid_o=0, pop_pc_o=0, pop_inst_o=0.
- count_o SHALL read 0 from the first edge with rst high.

Configuration
REQ-021 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined, forward the push directly to the outputs when count==0, push_valid_i=1, flush_i=0 and rst=0.
- In that case pop_valid_o=1, pop_pc_o=push_pc_i and pop_inst_o=push_inst_i in the same cycle.
- If pop_ready_i is also high, the entry SHALL NOT be stored and count stays 0.
REQ-022 SHALL, without FETCH_QUEUE_BYPASS_EN, contain no combinational path from push_* inputs to pop_* outputs, and obey the 1-cycle latency of REQ-012.

Verification (DEPTH=4)
REQ-023 SHALL cover fill: after reset, pop_ready_i=0, push PCs 0x1c000000/04/08/0c.
- Required: count_o reaches 4 and push_ready_o goes 0.
- A 5th push of PC 0x1c000010 is ignored and count stays 4.
REQ-024 SHALL cover drain: from the full state, pop_ready_i=1 for 5 cycles.
- Required: pop_pc_o = 0x1c000000, 04, 08, 0c in order, then pop_valid_o=0, pop_pc_o=0, count_o=0.
REQ-025 SHALL cover wrap: at count 2, hold push and pop both high for 10 cycles with sequential PCs.
- Required: count_o stays 2, pointers wrap twice, and the popped PC sequence is strictly ascending by 4.
REQ-026 SHALL cover flush: at count 3, assert flush_i together with a push of PC 0x1c000100.
- Required: pop_valid_o is 0 during the flush cycle.
- Next cycle: count_o=0 and pop_valid_o=0; 0x1c000100 is never popped.
REQ-027 SHALL cover bypass: when empty, push inst 0x02800c21 at PC 0x1c000020 with pop_ready_i=1.
- With FETCH_QUEUE_BYPASS_EN: pop_valid_o=1 with those values in the same cycle, and count_o stays 0.
- Without the macro: pop_valid_o=0 that cycle; the entry appears the next cycle with count_o=1.
REQ-028 SHALL cover reset priority: at count 2, assert rst together with flush_i and a push.
- Required: next cycle count_o=0, push_ready_o=0 and pop_valid_o=0 while rst is held.
- After rst drops, push_ready_o=1.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch stage, the instruction fetch queue and decode.
// master = the fetch/decode side that drives the queue, slave = the queue itself.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush_i;
    logic              push_valid_i;
    logic [ADDR_W-1:0] push_pc_i;
    logic [INST_W-1:0] push_inst_i;
    logic              push_ready_o;
    logic              pop_valid_o;
    logic [ADDR_W-1:0] pop_pc_o;
    logic [INST_W-1:0] pop_inst_o;
    logic              pop_ready_i;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output flush_i, push_valid_i, push_pc_i, push_inst_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_pc_o, pop_inst_o, count_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_pc_i, push_inst_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_pc_o, pop_inst_o, count_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction fetch queue (PC + instruction word) with branch flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to the pop outputs when the queue is empty.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    // Pointers carry one extra wrap bit above the index.
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              queue_live_s;
    logic              stored_valid_s;
    logic              bypass_s;
    logic              push_ready_s;
    logic              pop_valid_s;
    logic [ADDR_W-1:0] pop_pc_s;
    logic [INST_W-1:0] pop_inst_s;
    logic              push_fire_s;
    logic              pop_fire_s;
    logic              do_push_s;
    logic              do_pop_s;

    assign queue_live_s   = !rst && !bus.flush_i;
    assign stored_valid_s = queue_live_s && (count_q != {CNT_W{1'b0}});
    assign push_ready_s   = queue_live_s && (count_q != FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_s = queue_live_s && (count_q == {CNT_W{1'b0}}) && bus.push_valid_i;
`else
    assign bypass_s = 1'b0;
`endif

    // Head selection: forwarded push, stored head entry, or zeros when nothing is valid.
    always_comb begin
        pop_valid_s = 1'b0;
        pop_pc_s    = {ADDR_W{1'b0}};
        pop_inst_s  = {INST_W{1'b0}};
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass_s) begin
            pop_valid_s = 1'b1;
            pop_pc_s    = bus.push_pc_i;
            pop_inst_s  = bus.push_inst_i;
        end else if (stored_valid_s) begin
            pop_valid_s = 1'b1;
            pop_pc_s    = pc_mem[rd_ptr_q[PTR_W-1:0]];
            pop_inst_s  = inst_mem[rd_ptr_q[PTR_W-1:0]];
        end else begin
            pop_valid_s = 1'b0;
            pop_pc_s    = {ADDR_W{1'b0}};
            pop_inst_s  = {INST_W{1'b0}};
        end
`else
        if (stored_valid_s) begin
            pop_valid_s = 1'b1;
            pop_pc_s    = pc_mem[rd_ptr_q[PTR_W-1:0]];
            pop_inst_s  = inst_mem[rd_ptr_q[PTR_W-1:0]];
        end else begin
            pop_valid_s = 1'b0;
            pop_pc_s    = {ADDR_W{1'b0}};
            pop_inst_s  = {INST_W{1'b0}};
        end
`endif
    end

    assign push_fire_s = bus.push_valid_i && push_ready_s;
    assign pop_fire_s  = pop_valid_s && bus.pop_ready_i;
    // A forwarded entry consumed in the same cycle never touches storage.
    assign do_push_s   = push_fire_s && !(bypass_s && bus.pop_ready_i);
    assign do_pop_s    = pop_fire_s && !bypass_s;

    // Next-state for pointers and occupancy; flush discards everything including same-cycle traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = {(PTR_W + 1){1'b0}};
            rd_ptr_d = {(PTR_W + 1){1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset outranks flush and all traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(PTR_W + 1){1'b0}};
            rd_ptr_q <= {(PTR_W + 1){1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            pc_mem[wr_ptr_q[PTR_W-1:0]]   <= bus.push_pc_i;
            inst_mem[wr_ptr_q[PTR_W-1:0]] <= bus.push_inst_i;
        end
    end

    assign bus.push_ready_o = push_ready_s;
    assign bus.pop_valid_o  = pop_valid_s;
    assign bus.pop_pc_o     = pop_pc_s;
    assign bus.pop_inst_o   = pop_inst_s;
    assign bus.count_o      = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model (honours FETCH_QUEUE_BYPASS_EN).
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(AW), .INST_W(IW)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .INST_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] m_pc   [$];
    logic [IW-1:0] m_inst [$];
    logic [AW-1:0] obs_pops [$];

    logic          last_ready;
    logic          last_valid;
    logic [AW-1:0] last_pc;
    logic [IW-1:0] last_inst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check the head/handshake outputs, clock, update model, check occupancy.
    task automatic step(input logic r, input logic f, input logic pv,
                        input logic [AW-1:0] pc, input logic [IW-1:0] inst, input logic pr);
        logic          e_ready;
        logic          e_valid;
        logic          e_byp;
        logic [AW-1:0] e_pc;
        logic [IW-1:0] e_inst;
        logic          m_do_pop;
        logic          m_do_push;
        rst              = r;
        bus.flush_i      = f;
        bus.push_valid_i = pv;
        bus.push_pc_i    = pc;
        bus.push_inst_i  = inst;
        bus.pop_ready_i  = pr;
        #2;
        e_ready = !r && !f && (m_pc.size() != DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
        e_byp = !r && !f && (m_pc.size() == 0) && pv;
`else
        e_byp = 1'b0;
`endif
        e_valid = e_byp || (!r && !f && (m_pc.size() != 0));
        e_pc    = '0;
        e_inst  = '0;
        if (e_byp) begin
            e_pc   = pc;
            e_inst = inst;
        end else if (e_valid) begin
            e_pc   = m_pc[0];
            e_inst = m_inst[0];
        end
        last_ready = bus.push_ready_o;
        last_valid = bus.pop_valid_o;
        last_pc    = bus.pop_pc_o;
        last_inst  = bus.pop_inst_o;
        check_eq("push_ready", {63'd0, last_ready}, {63'd0, e_ready});
        check_eq("pop_valid",  {63'd0, last_valid}, {63'd0, e_valid});
        check_eq("pop_pc",     {32'd0, last_pc},    {32'd0, e_pc});
        check_eq("pop_inst",   {32'd0, last_inst},  {32'd0, e_inst});
        if (last_valid && pr) obs_pops.push_back(last_pc);
        @(posedge clk);
        if (r || f) begin
            m_pc.delete();
            m_inst.delete();
        end else if (!(e_byp && pr)) begin
            m_do_pop  = e_valid && pr && !e_byp;
            m_do_push = pv && e_ready;
            if (m_do_pop) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
            end
            if (m_do_push) begin
                m_pc.push_back(pc);
                m_inst.push_back(inst);
            end
        end
        #1;
        check_eq("count", {61'd0, bus.count_o}, 64'(m_pc.size()));
    endtask

    task automatic idle(input logic pr);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pr);
    endtask

    initial begin
        int hits;
        logic [AW-1:0] rpc;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("rst_count", {61'd0, bus.count_o}, 64'd0);
        check_eq("rst_ready", {63'd0, last_ready}, 64'd0);

        // Fill to DEPTH, then an ignored fifth push
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b1, 32'h1c000000 + 32'(4 * i), $urandom, 1'b0);
        check_eq("fill_count", {61'd0, bus.count_o}, 64'd4);
        step(1'b0, 1'b0, 1'b1, 32'h1c000010, $urandom, 1'b0);
        check_eq("fill_ready", {63'd0, last_ready}, 64'd0);
        check_eq("fill_count_held", {61'd0, bus.count_o}, 64'd4);

        // Drain in order
        obs_pops.delete();
        for (int i = 0; i < 5; i++) idle(1'b1);
        check_eq("drain_n", 64'(obs_pops.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_pops.size(); i++)
            check_eq("drain_pc", {32'd0, obs_pops[i]}, {32'd0, 32'h1c000000 + 32'(4 * i)});
        check_eq("drain_valid", {63'd0, last_valid}, 64'd0);
        check_eq("drain_pc_zero", {32'd0, last_pc}, 64'd0);
        check_eq("drain_count", {61'd0, bus.count_o}, 64'd0);

        // Wrap: steady push+pop at occupancy 2
        step(1'b0, 1'b0, 1'b1, 32'h1c000200, $urandom, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h1c000204, $urandom, 1'b0);
        obs_pops.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h1c000208 + 32'(4 * i), $urandom, 1'b1);
            check_eq("wrap_count", {61'd0, bus.count_o}, 64'd2);
        end
        check_eq("wrap_n", 64'(obs_pops.size()), 64'd10);
        if (obs_pops.size() > 0) check_eq("wrap_first", {32'd0, obs_pops[0]}, {32'd0, 32'h1c000200});
        for (int i = 1; i < obs_pops.size(); i++)
            check_eq("wrap_ascend", {32'd0, obs_pops[i]}, {32'd0, obs_pops[i-1] + 32'd4});

        // Flush at occupancy 3 with a same-cycle push
        step(1'b0, 1'b0, 1'b1, 32'h1c000230, $urandom, 1'b0);
        check_eq("pre_flush_count", {61'd0, bus.count_o}, 64'd3);
        step(1'b0, 1'b1, 1'b1, 32'h1c000100, $urandom, 1'b1);
        check_eq("flush_valid", {63'd0, last_valid}, 64'd0);
        check_eq("flush_count", {61'd0, bus.count_o}, 64'd0);
        idle(1'b1);
        check_eq("post_flush_valid", {63'd0, last_valid}, 64'd0);

        // Empty-queue push with decode ready
        step(1'b0, 1'b0, 1'b1, 32'h1c000020, 32'h02800c21, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("byp_valid", {63'd0, last_valid}, 64'd1);
        check_eq("byp_pc", {32'd0, last_pc}, {32'd0, 32'h1c000020});
        check_eq("byp_inst", {32'd0, last_inst}, {32'd0, 32'h02800c21});
        check_eq("byp_count", {61'd0, bus.count_o}, 64'd0);
`else
        check_eq("nobyp_valid", {63'd0, last_valid}, 64'd0);
        check_eq("nobyp_count", {61'd0, bus.count_o}, 64'd1);
        idle(1'b1);
        check_eq("nobyp_next_valid", {63'd0, last_valid}, 64'd1);
        check_eq("nobyp_next_pc", {32'd0, last_pc}, {32'd0, 32'h1c000020});
        check_eq("nobyp_next_inst", {32'd0, last_inst}, {32'd0, 32'h02800c21});
`endif

        // Reset outranks flush and push
        step(1'b0, 1'b0, 1'b1, 32'h1c000300, $urandom, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h1c000304, $urandom, 1'b0);
        check_eq("rp_pre_count", {61'd0, bus.count_o}, 64'd2);
        step(1'b1, 1'b1, 1'b1, 32'h1c000308, $urandom, 1'b0);
        check_eq("rp_count", {61'd0, bus.count_o}, 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("rp_ready_held", {63'd0, last_ready}, 64'd0);
        check_eq("rp_valid_held", {63'd0, last_valid}, 64'd0);
        idle(1'b0);
        check_eq("rp_ready_after", {63'd0, last_ready}, 64'd1);

        // Random traffic against the model (random PCs have low bits 2'b11)
        for (int i = 0; i < 500; i++) begin
            rpc = $urandom;
            rpc[1:0] = 2'b11;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0, rpc, $urandom, $urandom_range(0, 1) == 1);
        end

        hits = 0;
        foreach (obs_pops[i]) if (obs_pops[i] == 32'h1c000100) hits++;
        check_eq("flushed_never_popped", 64'(hits), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
